// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: pointer exchange with the write domain,
// memory read port, and the ready/valid stream toward the consumer.
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 8
);
  localparam int ASIZE = $clog2(DEPTH);

  logic [ASIZE:0]    wptr_gray;
  logic [ASIZE:0]    rptr_gray;
  logic [ASIZE-1:0]  raddr;
  logic              rden;
  logic              rd_empty;
  logic [DATASIZE-1:0] mem_rdata;
  logic [DATASIZE-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [ASIZE:0]    rd_count;

  // read controller side
  modport master (
    input  wptr_gray, mem_rdata, dout_ready,
    output rptr_gray, raddr, rden, rd_empty, dout, dout_valid, rd_count
  );

  // write domain / memory / consumer side
  modport slave (
    output wptr_gray, mem_rdata, dout_ready,
    input  rptr_gray, raddr, rden, rd_empty, dout, dout_valid, rd_count
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller: synchronizes the write pointer, owns the read
// pointer and empty/count flags, and turns the 1-cycle-latency memory read
// port into a full-throughput ready/valid stream via a 2-entry buffer.
package pkg_graybin;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 8
) (
  input logic           rclk,
  input logic           rrst,
  fifo_rd_ctrl_if.master bus
);
  import pkg_graybin::*;

  localparam int ASIZE = $clog2(DEPTH);
  localparam int PW    = ASIZE + 1;

  logic [PW-1:0]       wq1, wq2;
  logic [PW-1:0]       rbin, rbin_next, rgray_next;
  logic [PW-1:0]       rptr_gray, rd_count;
  logic                rd_empty;
  logic                rden, pop, inflight;
  logic [1:0]          occ, occ_left;
  logic [2:0]          occ_proj;
  logic [DATASIZE-1:0] head, skid;

  // Read issue: only fetch if the buffer can absorb the word once it lands,
  // counting what is already held and in flight, net of this cycle's pop.
  always_comb begin
    pop        = (occ != 2'd0) & bus.dout_ready;
    occ_left   = occ - {1'b0, pop};
    occ_proj   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    rden       = !rd_empty && (occ_proj <= 3'd1);
    rbin_next  = rbin + {{ASIZE{1'b0}}, rden};
    rgray_next = PW'(bin2gray(32'(rbin_next)));
  end

  // Two-flop synchronizer for the write pointer; only wq2 is consumed.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= bus.wptr_gray;
      wq2 <= wq1;
    end
  end

  // Read pointer and flags, all computed from the post-increment pointer so
  // empty is exact for the next cycle's issue decision.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rd_empty  <= 1'b1;
      rd_count  <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      rd_empty  <= (rgray_next == wq2);
      rd_count  <= PW'(gray2bin(32'(wq2))) - rbin_next;
    end
  end

  // Output buffer: skid shifts into head on pop; returning read data fills
  // the lowest free slot after the pop. Issue gating keeps occ+inflight <= 2.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= '0;
      skid     <= '0;
    end else begin
      inflight <= rden;
      occ      <= occ_left + {1'b0, inflight};
      if (pop && occ == 2'd2) head <= skid;
      if (inflight) begin
        if (occ_left == 2'd0) head <= bus.mem_rdata;
        else                  skid <= bus.mem_rdata;
      end
    end
  end

  assign bus.rden       = rden;
  assign bus.raddr      = rbin[ASIZE-1:0];
  assign bus.rptr_gray  = rptr_gray;
  assign bus.rd_empty   = rd_empty;
  assign bus.rd_count   = rd_count;
  assign bus.dout       = head;
  assign bus.dout_valid = (occ != 2'd0);
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries (power of two); ASIZE = $clog2(DEPTH).
REQ-003 SHALL have port rclk  input  1  read-domain clock; the block's only clock; all state on posedge rclk.
REQ-004 SHALL have port rrst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wptr_gray  input  ASIZE+1  write pointer, Gray-coded, from the write clock domain.
REQ-006 SHALL have port rptr_gray  output  ASIZE+1  registered read pointer, Gray-coded, to the write domain.
REQ-007 SHALL have port raddr  output  ASIZE  memory read address, equal to rbin[ASIZE-1:0].
REQ-008 SHALL have port rden  output  1  memory read strobe.
REQ-009 SHALL have port rd_empty  output  1  registered empty flag.
REQ-010 SHALL have port mem_rdata  input  DATASIZE  memory read data, valid one rclk cycle after rden.
REQ-011 SHALL have port dout  output  DATASIZE  stream data to consumer.
REQ-012 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-014 SHALL have port rd_count  output  ASIZE+1  registered words in the FIFO memory, not counting the output buffer.

Function
REQ-015 SHALL synchronize wptr_gray through two rclk flops (wq1, wq2); only wq2 is used downstream.
REQ-016 SHALL keep an ASIZE+1 binary read pointer rbin, incremented by 1 on each cycle rden=1, wrapping modulo 2^(ASIZE+1).
REQ-017 SHALL register rptr_gray = rbin_next ^ (rbin_next >> 1), using the pkg_graybin conversion functions.
REQ-018 SHALL register rd_empty = (Gray(rbin_next) == wq2).
REQ-019 SHALL hold a 2-entry output buffer (head drives dout, plus skid entry); occ = entries held (0..2).
REQ-020 SHALL track inflight = rden delayed one cycle; when inflight=1, mem_rdata is written to head if head is empty or popped this cycle, else to skid.
REQ-021 SHALL define pop = dout_valid & dout_ready; on pop, skid (if held) moves to head in the same cycle.
REQ-022 SHALL assert rden combinationally iff !rd_empty && (occ + inflight - pop) <= 1; rden SHALL never be 1 while rd_empty=1.
REQ-023 SHALL assert dout_valid iff occ >= 1; dout SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-024 SHALL sustain one word per cycle when the FIFO is non-empty and dout_ready is held at 1, after 2-cycle initial latency (rden -> head load -> dout_valid).
REQ-025 SHALL register rd_count = (gray2bin(wq2) - rbin_next) modulo 2^(ASIZE+1); the value is pessimistic (sync lag) and never exceeds DEPTH.
REQ-026 SHALL treat a wptr_gray change and a same-cycle read as independent: empty is re-evaluated against wq2 and rbin_next every cycle.
REQ-027 SHALL wrap raddr from DEPTH-1 to 0 while rbin MSB toggles, with no stall at the wrap.

Reset
REQ-028 SHALL, while rrst=1, asynchronously force rbin=0, rptr_gray=0, wq1=wq2=0, rd_empty=1, rd_count=0, occ=0, inflight=0, dout_valid=0, dout=0; rden SHALL be 0.
REQ-029 SHALL, on reset mid-transfer, discard any inflight word and buffer contents; the first read after release SHALL use raddr=0.
REQ-030 SHALL resume normal operation on the first rclk edge after rrst deasserts.

Verification
REQ-031 Reset: rrst=1 mid-stream -> rd_empty=1, dout_valid=0, rptr_gray=0, rden=0 immediately, without a clock edge.
REQ-032 Sync latency: wptr_gray 0->1 (Gray 0001) with rptr at 0 -> rd_empty falls 3 rclk edges later, rden=1 that cycle with raddr=0, dout_valid=1 two edges after rden.
REQ-033 Streaming: 8 words written (wptr_gray=Gray(8)=01100), dout_ready=1 -> 8 consecutive dout_valid beats, raddr 0..7, then rd_empty=1 and rptr_gray=01100.
REQ-034 Backpressure: 5 words available, dout_ready=0 -> exactly 2 rden pulses, occ=2, rd_count=3, dout stable; on dout_ready=1, the remaining words follow in order without loss or duplication.
REQ-035 Wrap: rbin=15, one more word written -> raddr goes 7 then 0, rbin wraps to 0, rptr_gray 01000 -> 00000, data order preserved.
REQ-036 Count: wptr_gray=Gray(6) with rbin=2 -> rd_count=4 after synchronization; rden never asserts while rd_empty=1 throughout all tests.
